// File: rtl/led_pwm_wb.sv
// Wishbone-attached multi-channel PWM LED controller with prescaler,
// period-aligned duty updates and triangle-wave breathing modulation.
module led_pwm_wb #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned PW    = 8,
  parameter int unsigned PRE_W = 12,
  parameter int unsigned DW    = 32
) (
  input  logic            clk_24m,
  input  logic            rst,
  input  logic [3:0]      wb_addr,
  input  logic [DW-1:0]   wb_wdata,
  output logic [DW-1:0]   wb_rdata,
  input  logic            wb_we,
  input  logic            wb_cyc,
  output logic            wb_ack,
  output logic [N_CH-1:0] pwm_out
);

  localparam int unsigned PRW = 2 * PW + 1;

  typedef enum logic {UP, DOWN} breath_t;

  logic [2:0]       ctrl;
  logic [PRE_W-1:0] presc;
  logic [15:0]      step;
  logic [PW-1:0]    duty [N_CH];
  logic [PW-1:0]    eff  [N_CH];
  logic [PW-1:0]    scaled [N_CH];
  logic [PRW-1:0]   prod [N_CH];

  logic [PRE_W-1:0] pre;
  logic [PW-1:0]    cnt;
  logic [PW-1:0]    lvl, lvl_nxt;
  logic [PW:0]      lvl_p1;
  logic [15:0]      sc, sc_nxt;
  breath_t          state, state_nxt;

  logic en, breathe, inv;
  logic tick, wrap;
  logic acc, wr;
  logic [DW-1:0] rd;
  logic unused_wdata;

  assign en      = ctrl[0];
  assign breathe = ctrl[1];
  assign inv     = ctrl[2];

  assign acc = wb_cyc & ~wb_ack;
  assign wr  = acc & wb_we;

  assign unused_wdata = ^wb_wdata;

  // Register file
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      ctrl  <= '0;
      presc <= '0;
      step  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) duty[i] <= '0;
    end else if (wr) begin
      case (wb_addr)
        4'd0: ctrl  <= wb_wdata[2:0];
        4'd1: presc <= wb_wdata[PRE_W-1:0];
        4'd2: step  <= wb_wdata[15:0];
        default: begin
          for (int unsigned i = 0; i < N_CH; i++)
            if (wb_addr == 4'(4 + i)) duty[i] <= wb_wdata[PW-1:0];
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (wb_addr)
      4'd0: begin
        rd[2:0]     = ctrl;
        rd[16 +: PW] = lvl;
      end
      4'd1: rd[PRE_W-1:0] = presc;
      4'd2: rd[15:0]      = step;
      default: begin
        for (int unsigned i = 0; i < N_CH; i++)
          if (wb_addr == 4'(4 + i)) rd[PW-1:0] = duty[i];
      end
    endcase
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack   <= acc;
      wb_rdata <= acc ? rd : '0;
    end
  end

  // Prescaler and period counter
  assign tick = en & (pre == presc);
  assign wrap = tick & (cnt == '1);

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
    end else if (!en) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) cnt <= cnt + PW'(1);
    end
  end

  // Breathing-scaled duty: (duty * (lvl+1)) >> PW
  assign lvl_p1 = {1'b0, lvl} + (PW + 1)'(1);

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      prod[i]   = PRW'(duty[i]) * PRW'(lvl_p1);
      scaled[i] = prod[i][PW +: PW];
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) eff[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!en)       eff[i] <= duty[i];
        else if (wrap) eff[i] <= breathe ? scaled[i] : duty[i];
      end
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        pwm_out[i] <= en ? ((cnt < eff[i]) ^ inv) : inv;
    end
  end

  // Breathing state machine
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state <= UP;
      lvl   <= '0;
      sc    <= '0;
    end else begin
      state <= state_nxt;
      lvl   <= lvl_nxt;
      sc    <= sc_nxt;
    end
  end

  // Level is only preset to full while running, so it keeps its reset value until first enable
  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    sc_nxt    = sc;
    if (!en) begin
      sc_nxt = '0;
    end else if (!breathe) begin
      lvl_nxt   = '1;
      sc_nxt    = '0;
      state_nxt = DOWN;
    end else if (wrap) begin
      if (sc == step) begin
        sc_nxt = '0;
        case (state)
          UP: begin
            if (lvl == '1) begin
              state_nxt = DOWN;
              lvl_nxt   = lvl - PW'(1);
            end else begin
              lvl_nxt = lvl + PW'(1);
            end
          end
          DOWN: begin
            if (lvl == '0) begin
              state_nxt = UP;
              lvl_nxt   = lvl + PW'(1);
            end else begin
              lvl_nxt = lvl - PW'(1);
            end
          end
          default: state_nxt = UP;
        endcase
      end else begin
        sc_nxt = sc + 16'd1;
      end
    end
  end

endmodule
